tube_bcd_feeder: RTL and testbench
==================================

Name: tube_bcd_feeder

Overview:
- Upstream producer for the digital-tube peripheral.
- Takes a 32-bit unsigned binary value and converts it to packed BCD with a sequential double-dabble (one shift per cycle).
- Then issues two bus-style write beats (addr/byteen/wdata) that load the tube's display register (offset 0) and its auxiliary digit register (offset 4).
- Lets software or a counter hand over plain binary and see a decimal readout.

Parameters:
- BASE_ADDR, 32'h0000_7F50, byte address of the tube display register; the auxiliary digit register is BASE_ADDR+4.
- CONV_BITS, 32, number of input bits and double-dabble iterations. Fixed at 32; any other value is unsupported.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  source presents in_data
- in_data  input  32  unsigned binary value to display
- in_ready  output  1  block can accept; high only in IDLE
- out_addr  output  32  write address to tube peripheral
- out_byteen  output  4  byte enables; 4'b0000 = no write
- out_wdata  output  32  write data
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse on the final write beat
- overflow  output  1  last value was >= 1,000,000,000 and was saturated; sticky until next accept

Behaviour:
Interface decided:
- One clock (clk).
- Reset is synchronous and active-high (reset).

Reset (sampled at posedge, overrides everything):
- state=IDLE, in_ready=1, busy=0, done=0, overflow=0.
- out_addr=0, out_byteen=0, out_wdata=0.
- Internal shift registers cleared.

States: IDLE -> CONV -> WR0 -> WR1 -> IDLE.
- IDLE: in_ready=1. A handshake is in_valid&&in_ready at a posedge; call that cycle 0. On handshake:
  - bin_sr<=in_data, bcd_sr(40 bits, 10 digits)<=0, iter<=0, overflow<=0.
  - Go to CONV.
- CONV: each cycle, do both steps on the same cycle:
  - every 4-bit digit of bcd_sr that is >=5 gets +3;
  - then {bcd_sr,bin_sr} shifts left by 1.
  - Stay for exactly 32 cycles (cycles 1..32), then go to WR0.
- WR0 (cycle 33):
  - out_addr=BASE_ADDR, out_byteen=4'b1111.
  - out_wdata=bcd_sr[31:0] (digits 7..0).
- WR1 (cycle 34):
  - out_addr=BASE_ADDR+4, out_byteen=4'b0001.
  - out_wdata={28'b0,bcd_sr[35:32]} (digit 8).
  - done=1.
  - Next state is IDLE; the earliest next accept is cycle 35.
- Saturation: if bcd_sr[39:36]!=0 at end of CONV:
  - WR0 data=32'h9999_9999, WR1 data=32'h0000_0009.
  - overflow<=1, registered entering WR0.
- Outside WR0/WR1: out_byteen=0, out_addr=0, out_wdata=0. The tube's scan counter only advances while byteen==0, so writes must be limited to exactly 2 cycles per value.
- Write outputs, busy and done are registered (driven from state, no combinational path from in_valid).
- in_valid while busy is ignored; the source must hold its data until in_ready.
- Reset mid-operation: abort, no further write beats, return to IDLE on the next cycle.

Optional Feature:
HEX_BYPASS_EN
- Defined:
  - Adds input port in_hex (1 bit), sampled with the handshake.
  - If in_hex=1: skip CONV; go IDLE->WR0->WR1.
  - WR0 data=in_data unchanged; WR1 data=0.
  - overflow stays 0; latency is 2 cycles (accept cycle 0, WR0 cycle 1, WR1 cycle 2).
  - If in_hex=0: behaviour as above.
- Undefined:
  - Port absent; every value is converted.

Test Plan:
1. Reset for 2 cycles -> in_ready=1, busy=0, out_byteen=0, done=0, overflow=0.
2. Accept in_data=12,345,678 at cycle 0:
   - cycle 33: addr=BASE_ADDR, byteen=4'hF, wdata=32'h1234_5678;
   - cycle 34: addr=BASE_ADDR+4, byteen=4'h1, wdata=0, done=1.
3. in_data=987,654,321 -> WR0 wdata=32'h8765_4321, WR1 wdata=32'h0000_0009, overflow=0.
4. in_data=32'hFFFF_FFFF -> WR0 wdata=32'h9999_9999, WR1 wdata=9, overflow=1. Then in_data=0 -> WR0 wdata=0, WR1 wdata=0, overflow=0.
5. Hold in_valid=1 with value A then B:
   - in_ready=0 during cycles 1..34, only A accepted;
   - B accepted at cycle 35; byteen=0 on every cycle except the two write beats per value.
6. Assert reset at cycle 10 during CONV -> no write beats ever occur for that value; IDLE with in_ready=1 on the cycle after reset deasserts.

Source files
------------

// File: rtl/tube_bcd_feeder.sv
// Binary-to-BCD feeder for the digital-tube peripheral: sequential double-dabble, then two write beats.
// Optional macro HEX_BYPASS_EN adds in_hex to pass raw data straight to the write beats.
module tube_bcd_feeder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F50,
    parameter int          CONV_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
`ifdef HEX_BYPASS_EN
    input  logic        in_hex,
`endif
    output logic        in_ready,
    output logic [31:0] out_addr,
    output logic [3:0]  out_byteen,
    output logic [31:0] out_wdata,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, WR0 = 2'd2, WR1 = 2'd3} state_t;

    state_t      state, next_state;
    logic [31:0] bin_sr, bin_next;
    logic [39:0] bcd_sr, bcd_adj, bcd_next;
    logic [5:0]  iter;
    logic        hex_r;
    logic        hex_sel;
    logic        handshake;
    logic        sat;

    function automatic logic [39:0] add3(input logic [39:0] v);
        logic [39:0] r;
        r = v;
        for (int d = 0; d < 10; d++) begin
            if (v[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = v[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

`ifdef HEX_BYPASS_EN
    assign hex_sel = in_hex;
`else
    assign hex_sel = 1'b0;
`endif

    assign handshake = in_valid && in_ready;

    // Next-state logic and the combinational double-dabble step
    always_comb begin
        next_state = state;
        bcd_adj    = add3(bcd_sr);
        bcd_next   = {bcd_adj[38:0], bin_sr[31]};
        bin_next   = {bin_sr[30:0], 1'b0};
        sat        = (bcd_next[39:36] != 4'd0);
        case (state)
            IDLE: begin
                if (handshake) begin
                    next_state = hex_sel ? WR0 : CONV;
                end else begin
                    next_state = IDLE;
                end
            end
            CONV: begin
                if (iter == 6'(CONV_BITS - 1)) begin
                    next_state = WR0;
                end else begin
                    next_state = CONV;
                end
            end
            WR0:     next_state = WR1;
            WR1:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Conversion datapath, overflow flag and registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_sr     <= 32'd0;
            bcd_sr     <= 40'd0;
            iter       <= 6'd0;
            hex_r      <= 1'b0;
            overflow   <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_addr   <= 32'd0;
            out_byteen <= 4'd0;
            out_wdata  <= 32'd0;
        end else begin
            in_ready   <= (next_state == IDLE);
            busy       <= (next_state != IDLE);
            done       <= (next_state == WR1);
            out_addr   <= 32'd0;
            out_byteen <= 4'd0;
            out_wdata  <= 32'd0;

            case (state)
                IDLE: begin
                    if (handshake) begin
                        bin_sr   <= in_data;
                        bcd_sr   <= 40'd0;
                        iter     <= 6'd0;
                        hex_r    <= hex_sel;
                        overflow <= 1'b0;
                    end
                end
                CONV: begin
                    bcd_sr <= bcd_next;
                    bin_sr <= bin_next;
                    iter   <= iter + 6'd1;
                    if (next_state == WR0) begin
                        overflow <= sat;
                    end
                end
                default: begin
                end
            endcase

            // The WR0 beat is loaded on the edge that finishes the last shift, so it uses bcd_next
            case (next_state)
                WR0: begin
                    out_addr   <= BASE_ADDR;
                    out_byteen <= 4'b1111;
                    if (state == IDLE) begin
                        out_wdata <= in_data;
                    end else if (sat) begin
                        out_wdata <= 32'h9999_9999;
                    end else begin
                        out_wdata <= bcd_next[31:0];
                    end
                end
                WR1: begin
                    out_addr   <= BASE_ADDR + 32'd4;
                    out_byteen <= 4'b0001;
                    if (hex_r) begin
                        out_wdata <= 32'd0;
                    end else if (overflow) begin
                        out_wdata <= 32'h0000_0009;
                    end else begin
                        out_wdata <= {28'd0, bcd_sr[35:32]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tube_bcd_feeder.sv
// Directed self-checking bench for tube_bcd_feeder: reset, conversions, saturation, back-to-back, abort.
module tb_tube_bcd_feeder;

    localparam logic [31:0] BASE = 32'h0000_7F50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
`ifdef HEX_BYPASS_EN
    logic        in_hex = 1'b0;
`endif
    logic        in_ready;
    logic [31:0] out_addr;
    logic [3:0]  out_byteen;
    logic [31:0] out_wdata;
    logic        busy;
    logic        done;
    logic        overflow;

    int total = 0;
    int bad = 0;

    tube_bcd_feeder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
`ifdef HEX_BYPASS_EN
        .in_hex(in_hex),
`endif
        .in_ready(in_ready), .out_addr(out_addr), .out_byteen(out_byteen),
        .out_wdata(out_wdata), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one value: handshake edge, 31 quiet CONV cycles, WR0, WR1, back in IDLE
    task automatic run_value(input logic [31:0] d, input logic [31:0] e0,
                             input logic [31:0] e1, input logic eov);
        int quiet_bad;
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        quiet_bad = 0;
        for (int i = 1; i < 32; i++) begin
            tick();
            if (out_byteen !== 4'd0 || busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0)
                quiet_bad++;
        end
        total++;
        if (quiet_bad != 0) begin
            bad++;
            $display("FAIL conv_quiet data=%h: %0d bad cycles, required 0", d, quiet_bad);
        end
        tick();
        total++;
        if (out_addr !== BASE || out_byteen !== 4'hF || out_wdata !== e0 || done !== 1'b0 || overflow !== eov) begin
            bad++;
            $display("FAIL wr0 data=%h: got addr=%h be=%h wd=%h done=%b ov=%b, required addr=%h be=f wd=%h done=0 ov=%b",
                     d, out_addr, out_byteen, out_wdata, done, overflow, BASE, e0, eov);
        end
        tick();
        total++;
        if (out_addr !== BASE + 32'd4 || out_byteen !== 4'h1 || out_wdata !== e1 || done !== 1'b1) begin
            bad++;
            $display("FAIL wr1 data=%h: got addr=%h be=%h wd=%h done=%b, required addr=%h be=1 wd=%h done=1",
                     d, out_addr, out_byteen, out_wdata, done, BASE + 32'd4, e1);
        end
        tick();
        total++;
        if (out_byteen !== 4'd0 || out_wdata !== 32'd0 || done !== 1'b0 || in_ready !== 1'b1 ||
            busy !== 1'b0 || overflow !== eov) begin
            bad++;
            $display("FAIL post_idle data=%h: got be=%h wd=%h done=%b rdy=%b busy=%b ov=%b, required 0 0 0 1 0 %b",
                     d, out_byteen, out_wdata, done, in_ready, busy, overflow, eov);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_byteen !== 4'd0 || done !== 1'b0 ||
            overflow !== 1'b0 || out_addr !== 32'd0 || out_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset: got rdy=%b busy=%b be=%h done=%b ov=%b addr=%h wd=%h, required 1 0 0 0 0 0 0",
                     in_ready, busy, out_byteen, done, overflow, out_addr, out_wdata);
        end
    endtask

    task automatic test_convert();
        run_value(32'd12345678, 32'h1234_5678, 32'h0000_0000, 1'b0);
        run_value(32'd987654321, 32'h8765_4321, 32'h0000_0009, 1'b0);
        run_value(32'd999999999, 32'h9999_9999, 32'h0000_0009, 1'b0);
        run_value(32'd1000000007, 32'h9999_9999, 32'h0000_0009, 1'b1);
    endtask

    task automatic test_saturate();
        run_value(32'hFFFF_FFFF, 32'h9999_9999, 32'h0000_0009, 1'b1);
        run_value(32'd0, 32'h0000_0000, 32'h0000_0000, 1'b0);
    endtask

    // in_valid held high across two values; B waits until in_ready returns
    task automatic test_back_to_back();
        int beats_a;
        int beats_b;
        int stray;
        in_data  = 32'd42;
        in_valid = 1'b1;
        tick();
        beats_a = 0;
        beats_b = 0;
        stray   = 0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready_c1: got %b, required 0", in_ready);
        end
        in_data = 32'd7;
        for (int i = 1; i <= 69; i++) begin
            tick();
            if (i == 32 && out_byteen === 4'hF && out_wdata === 32'h0000_0042) beats_a++;
            if (i == 33 && out_byteen === 4'h1 && out_wdata === 32'd0 && done === 1'b1) beats_a++;
            if (i == 67 && out_byteen === 4'hF && out_wdata === 32'h0000_0007) beats_b++;
            if (i == 68 && out_byteen === 4'h1 && out_wdata === 32'd0 && done === 1'b1) beats_b++;
            if (i == 35) in_valid = 1'b0;
            if (i != 32 && i != 33 && i != 67 && i != 68 && out_byteen !== 4'd0) stray++;
            if (i <= 33 && in_ready !== 1'b0) stray++;
            if (i == 34) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_ready_c35: got %b, required 1", in_ready);
                end
            end
            if (i == 35) begin
                total++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_accept_b: got rdy=%b busy=%b, required 0 1", in_ready, busy);
                end
            end
        end
        total++;
        if (beats_a != 2 || beats_b != 2 || stray != 0) begin
            bad++;
            $display("FAIL b2b_beats: got a=%0d b=%0d stray=%0d, required 2 2 0", beats_a, beats_b, stray);
        end
    endtask

    // Reset asserted mid-conversion: no beats for the aborted value
    task automatic test_reset_mid();
        int stray;
        in_data  = 32'd555;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_byteen !== 4'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_idle: got rdy=%b busy=%b be=%h done=%b, required 1 0 0 0",
                     in_ready, busy, out_byteen, done);
        end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_byteen !== 4'd0 || done !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL reset_mid_beats: got %0d write cycles, required 0", stray);
        end
    endtask

`ifdef HEX_BYPASS_EN
    task automatic test_hex();
        in_data  = 32'hDEAD_BEEF;
        in_hex   = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_hex   = 1'b0;
        total++;
        if (out_addr !== BASE || out_byteen !== 4'hF || out_wdata !== 32'hDEAD_BEEF || overflow !== 1'b0) begin
            bad++;
            $display("FAIL hex_wr0: got be=%h wd=%h ov=%b, required f deadbeef 0", out_byteen, out_wdata, overflow);
        end
        tick();
        total++;
        if (out_byteen !== 4'h1 || out_wdata !== 32'd0 || done !== 1'b1) begin
            bad++;
            $display("FAIL hex_wr1: got be=%h wd=%h done=%b, required 1 0 1", out_byteen, out_wdata, done);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_convert();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
`ifdef HEX_BYPASS_EN
        test_hex();
        run_value(32'd12345678, 32'h1234_5678, 32'h0000_0000, 1'b0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
